// File: rtl/graphics_datapath_if.sv
// Control and pixel/status signals between the drawing FSM side and the tile datapath.
interface graphics_datapath_if;
  logic       ld_tile;
  logic [1:0] tile_num;
  logic       ld_flash;
  logic       ld_previous;
  logic       writeEnable;
  logic       counterEnable;
  logic       ld_delay;
  logic       delayEN;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       draw_done;
  logic       delay_done;

  modport slave (
    input  ld_tile, tile_num, ld_flash, ld_previous,
    input  writeEnable, counterEnable, ld_delay, delayEN,
    output x, y, colour, plot, draw_done, delay_done
  );

  modport master (
    output ld_tile, tile_num, ld_flash, ld_previous,
    output writeEnable, counterEnable, ld_delay, delayEN,
    input  x, y, colour, plot, draw_done, delay_done
  );
endinterface

// File: rtl/graphics_datapath.sv
// Tile drawing datapath: 8x8 tile pixel generator with flash/restore colour and a pausable delay timer.
// Pixel outputs have one cycle of latency; no backpressure, the controller paces via writeEnable/counterEnable.
module graphics_datapath #(
  parameter int DELAY_CYCLES = 25000000
) (
  input logic             clock,
  input logic             resetn,
  graphics_datapath_if.slave io
);
  localparam int DW = $clog2(DELAY_CYCLES);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} delay_state_t;

  logic [1:0]   tile_reg;
  logic [7:0]   x_origin;
  logic [6:0]   y_origin;
  logic [2:0]   colour_reg;
  logic [5:0]   cnt;
  delay_state_t state;
  logic [DW-1:0] dcnt;

  function automatic logic [2:0] base_colour(input logic [1:0] t);
    case (t)
      2'd0:    return 3'b100;
      2'd1:    return 3'b010;
      2'd2:    return 3'b001;
      default: return 3'b110;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (!resetn) begin
      tile_reg      <= 2'd0;
      x_origin      <= 8'd64;
      y_origin      <= 7'd44;
      colour_reg    <= 3'b100;
      cnt           <= 6'd0;
      io.x          <= 8'd0;
      io.y          <= 7'd0;
      io.colour     <= 3'd0;
      io.plot       <= 1'b0;
      io.draw_done  <= 1'b0;
    end else begin
      if (io.ld_tile) begin
        tile_reg <= io.tile_num;
        x_origin <= io.tile_num[0] ? 8'd88 : 8'd64;
        y_origin <= io.tile_num[1] ? 7'd68 : 7'd44;
      end
      // Restore uses the tile latched before this cycle, even if ld_tile coincides.
      if (io.ld_flash)
        colour_reg <= 3'b111;
      else if (io.ld_previous)
        colour_reg <= base_colour(tile_reg);
      else if (io.ld_tile)
        colour_reg <= base_colour(io.tile_num);

      if (io.ld_tile || io.ld_flash || io.ld_previous)
        cnt <= 6'd0;
      else if (io.counterEnable)
        cnt <= cnt + 6'd1;

      io.plot      <= io.writeEnable;
      io.draw_done <= io.writeEnable && io.counterEnable && (cnt == 6'd63);
      if (io.writeEnable) begin
        io.x      <= x_origin + {5'd0, cnt[2:0]};
        io.y      <= y_origin + {4'd0, cnt[5:3]};
        io.colour <= colour_reg;
      end
    end
  end

  // Counter reaching zero still needs one enabled cycle to finish: DELAY_CYCLES enabled cycles total.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state         <= IDLE;
      dcnt          <= '0;
      io.delay_done <= 1'b0;
    end else if (io.ld_delay) begin
      state         <= COUNT;
      dcnt          <= DW'(DELAY_CYCLES - 1);
      io.delay_done <= 1'b0;
    end else begin
      case (state)
        COUNT: begin
          if (io.delayEN) begin
            if (dcnt != '0) begin
              dcnt <= dcnt - DW'(1);
            end else begin
              state         <= DONE;
              io.delay_done <= 1'b1;
            end
          end
        end
        DONE:    io.delay_done <= 1'b1;
        default: io.delay_done <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_graphics_datapath.sv
// Directed bench for graphics_datapath: vector table for single-cycle behaviour, hand sequences for draws, delay and reset.
module tb_graphics_datapath;
  logic clock;
  logic resetn;
  int   n_cmp = 0;
  int   n_err = 0;

  graphics_datapath_if gif();

  graphics_datapath #(.DELAY_CYCLES(4)) dut (
    .clock (clock),
    .resetn(resetn),
    .io    (gif.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       lt;
    logic [1:0] tn;
    logic       lf;
    logic       lp;
    logic       we;
    logic       ce;
    logic       ld;
    logic       de;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] col;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic lt, input logic [1:0] tn, input logic lf, input logic lp,
                       input logic we, input logic ce, input logic ld, input logic de);
    gif.ld_tile       = lt;
    gif.tile_num      = tn;
    gif.ld_flash      = lf;
    gif.ld_previous   = lp;
    gif.writeEnable   = we;
    gif.counterEnable = ce;
    gif.ld_delay      = ld;
    gif.delayEN       = de;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic draw64(input string tag, input int xo, input int yo, input logic [2:0] col);
    for (int i = 0; i < 64; i++) begin
      drive(0, 2'd0, 0, 0, 1, 1, 0, 0);
      tick();
      check({tag, "_plot"}, 32'(gif.plot), 32'd1);
      check({tag, "_x"}, 32'(gif.x), 32'(xo + i % 8));
      check({tag, "_y"}, 32'(gif.y), 32'(yo + i / 8));
      check({tag, "_colour"}, 32'(gif.colour), 32'(col));
      check({tag, "_draw_done"}, 32'(gif.draw_done), 32'(i == 63));
    end
    drive(0, 2'd0, 0, 0, 0, 0, 0, 0);
    tick();
    check({tag, "_plot_after"}, 32'(gif.plot), 32'd0);
    check({tag, "_draw_done_after"}, 32'(gif.draw_done), 32'd0);
  endtask

  initial begin
    //          lt  tn    lf lp we ce ld de  plot x      y      col
    vecs[0]  = '{1, 2'd0, 0, 0, 0, 0, 0, 0,  0, 8'd0,  7'd0,  3'b000};
    vecs[1]  = '{0, 2'd0, 0, 0, 1, 1, 0, 0,  1, 8'd64, 7'd44, 3'b100};
    vecs[2]  = '{0, 2'd0, 0, 0, 1, 0, 0, 0,  1, 8'd65, 7'd44, 3'b100};
    vecs[3]  = '{0, 2'd0, 0, 0, 0, 1, 0, 1,  0, 8'd65, 7'd44, 3'b100};
    vecs[4]  = '{0, 2'd0, 0, 0, 1, 1, 0, 0,  1, 8'd66, 7'd44, 3'b100};
    vecs[5]  = '{1, 2'd3, 1, 0, 1, 1, 0, 0,  1, 8'd67, 7'd44, 3'b100};
    vecs[6]  = '{0, 2'd0, 0, 0, 1, 1, 0, 0,  1, 8'd88, 7'd68, 3'b111};
    vecs[7]  = '{0, 2'd0, 0, 1, 1, 0, 0, 0,  1, 8'd89, 7'd68, 3'b111};
    vecs[8]  = '{0, 2'd0, 0, 0, 1, 1, 0, 0,  1, 8'd88, 7'd68, 3'b110};
    vecs[9]  = '{0, 2'd0, 1, 1, 0, 0, 0, 0,  0, 8'd88, 7'd68, 3'b110};
    vecs[10] = '{0, 2'd0, 0, 0, 1, 0, 0, 1,  1, 8'd88, 7'd68, 3'b111};
    vecs[11] = '{1, 2'd1, 0, 0, 0, 1, 0, 0,  0, 8'd88, 7'd68, 3'b111};
    vecs[12] = '{0, 2'd0, 0, 0, 1, 1, 0, 0,  1, 8'd88, 7'd44, 3'b010};
    vecs[13] = '{1, 2'd2, 0, 0, 0, 0, 0, 0,  0, 8'd88, 7'd44, 3'b010};
    vecs[14] = '{0, 2'd0, 0, 0, 1, 1, 0, 0,  1, 8'd64, 7'd68, 3'b001};

    resetn = 1'b0;
    drive(1, 2'd3, 1, 0, 1, 1, 1, 1);
    tick();
    tick();
    check("rst_plot", 32'(gif.plot), 32'd0);
    check("rst_x", 32'(gif.x), 32'd0);
    check("rst_y", 32'(gif.y), 32'd0);
    check("rst_colour", 32'(gif.colour), 32'd0);
    check("rst_draw_done", 32'(gif.draw_done), 32'd0);
    check("rst_delay_done", 32'(gif.delay_done), 32'd0);
    resetn = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].lt, vecs[i].tn, vecs[i].lf, vecs[i].lp,
            vecs[i].we, vecs[i].ce, vecs[i].ld, vecs[i].de);
      tick();
      check($sformatf("vec%0d_plot", i), 32'(gif.plot), 32'(vecs[i].plot));
      check($sformatf("vec%0d_x", i), 32'(gif.x), 32'(vecs[i].x));
      check($sformatf("vec%0d_y", i), 32'(gif.y), 32'(vecs[i].y));
      check($sformatf("vec%0d_colour", i), 32'(gif.colour), 32'(vecs[i].col));
      check($sformatf("vec%0d_draw_done", i), 32'(gif.draw_done), 32'd0);
      check($sformatf("vec%0d_delay_done", i), 32'(gif.delay_done), 32'd0);
    end

    // Full tile 2 draw.
    drive(1, 2'd2, 0, 0, 0, 0, 0, 0);
    tick();
    draw64("t2", 64, 68, 3'b001);

    // Tile 1 flashed, then restored.
    drive(1, 2'd1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 2'd0, 1, 0, 0, 0, 0, 0);
    tick();
    draw64("t1_flash", 88, 44, 3'b111);
    drive(0, 2'd0, 0, 1, 0, 0, 0, 0);
    tick();
    draw64("t1_prev", 88, 44, 3'b010);

    // Delay: continuous enable.
    drive(0, 2'd0, 0, 0, 0, 0, 1, 0);
    tick();
    check("dly_armed", 32'(gif.delay_done), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      drive(0, 2'd0, 0, 0, 0, 0, 0, 1);
      tick();
      check($sformatf("dly_run%0d", i), 32'(gif.delay_done), 32'(i == 4));
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 2'd0, 0, 0, 0, 0, 0, i[0]);
      tick();
      check($sformatf("dly_hold%0d", i), 32'(gif.delay_done), 32'd1);
    end

    // Delay: pause for 3 cycles mid-count.
    drive(0, 2'd0, 0, 0, 0, 0, 1, 0);
    tick();
    check("pause_armed", 32'(gif.delay_done), 32'd0);
    for (int i = 1; i <= 7; i++) begin
      drive(0, 2'd0, 0, 0, 0, 0, 0, (i < 3 || i > 5) ? 1'b1 : 1'b0);
      tick();
      check($sformatf("pause_c%0d", i), 32'(gif.delay_done), 32'(i == 7));
    end

    // Re-arm from DONE with delayEN also high.
    drive(0, 2'd0, 0, 0, 0, 0, 1, 1);
    tick();
    check("rearm_clear", 32'(gif.delay_done), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      drive(0, 2'd0, 0, 0, 0, 0, 0, 1);
      tick();
      check($sformatf("rearm_run%0d", i), 32'(gif.delay_done), 32'(i == 4));
    end

    // Reset during pixel 30 of a draw and while the delay is counting.
    drive(1, 2'd0, 0, 0, 0, 0, 1, 0);
    tick();
    for (int i = 0; i < 30; i++) begin
      drive(0, 2'd0, 0, 0, 1, 1, 0, (i < 2) ? 1'b1 : 1'b0);
      tick();
    end
    check("pre_rst_x", 32'(gif.x), 32'd69);
    check("pre_rst_y", 32'(gif.y), 32'd47);
    check("pre_rst_delay_done", 32'(gif.delay_done), 32'd0);
    resetn = 1'b0;
    drive(1, 2'd3, 0, 0, 1, 1, 0, 1);
    tick();
    check("mid_rst_plot", 32'(gif.plot), 32'd0);
    check("mid_rst_x", 32'(gif.x), 32'd0);
    check("mid_rst_y", 32'(gif.y), 32'd0);
    check("mid_rst_colour", 32'(gif.colour), 32'd0);
    check("mid_rst_draw_done", 32'(gif.draw_done), 32'd0);
    check("mid_rst_delay_done", 32'(gif.delay_done), 32'd0);
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(0, 2'd0, 0, 0, 0, 0, 0, 1);
      tick();
      check($sformatf("post_rst_plot%0d", i), 32'(gif.plot), 32'd0);
      check($sformatf("post_rst_delay_done%0d", i), 32'(gif.delay_done), 32'd0);
    end
    drive(0, 2'd0, 0, 0, 1, 0, 0, 0);
    tick();
    check("post_rst_we_plot", 32'(gif.plot), 32'd1);
    check("post_rst_we_x", 32'(gif.x), 32'd64);
    check("post_rst_we_y", 32'(gif.y), 32'd44);
    drive(0, 2'd0, 0, 0, 0, 0, 0, 0);
    tick();
    check("post_rst_idle_plot", 32'(gif.plot), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/graphics_datapath.md
GRAPHICS_DATAPATH -- requirements
Module: graphics_datapath

Interface
REQ-001 SHALL have parameter DELAY_CYCLES, default 25000000, giving the flash/hold delay length in clock cycles (minimum 2).
REQ-002 SHALL have port clock  in  1  system clock, all state on posedge.
REQ-003 SHALL have port resetn  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port ld_tile  in  1  latch tile_num, load that tile's origin and base colour.
REQ-005 SHALL have port tile_num  in  2  tile index 0..3, sampled only when ld_tile=1.
REQ-006 SHALL have port ld_flash  in  1  load flash colour for the current tile.
REQ-007 SHALL have port ld_previous  in  1  restore the current tile's base colour.
REQ-008 SHALL have port writeEnable  in  1  emit one pixel this cycle.
REQ-009 SHALL have port counterEnable  in  1  advance the pixel counter.
REQ-010 SHALL have port ld_delay  in  1  arm the delay timer.
REQ-011 SHALL have port delayEN  in  1  run the delay timer.
REQ-012 SHALL have port x  out  8  VGA pixel column, registered.
REQ-013 SHALL have port y  out  7  VGA pixel row, registered.
REQ-014 SHALL have port colour  out  3  pixel colour {R,G,B}, registered.
REQ-015 SHALL have port plot  out  1  write strobe to the VGA adapter, registered.
REQ-016 SHALL have port draw_done  out  1  one-cycle pulse when pixel 63 of a tile is emitted.
REQ-017 SHALL have port delay_done  out  1  sticky, high when the armed delay has expired.

Function
REQ-018 Tile geometry SHALL be 8x8 pixels, with origins: tile0 (64,44), tile1 (88,44), tile2 (64,68), tile3 (88,68).
REQ-019 Base colours SHALL be: tile0 3'b100, tile1 3'b010, tile2 3'b001, tile3 3'b110; the flash colour SHALL be 3'b111.
REQ-020 On ld_tile, the block SHALL latch tile_num into tile_reg and load the origin registers and the base colour into the colour register, effective next cycle.
REQ-021 On ld_flash, the colour register SHALL become 3'b111; tile_reg and the origin registers SHALL be unchanged.
REQ-022 On ld_previous, the colour register SHALL become the base colour of tile_reg; tile_reg SHALL be unchanged.
REQ-023 Colour-load priority when loads coincide SHALL be ld_flash > ld_previous > ld_tile; tile_reg and the origins SHALL still load on any ld_tile.
REQ-024 The 6-bit pixel counter SHALL clear to 0 on any of ld_tile/ld_flash/ld_previous, with clear overriding counterEnable.
REQ-025 Otherwise the counter SHALL increment by 1 per cycle with counterEnable=1, wrapping 63->0.
REQ-026 On a cycle with writeEnable=1, the next cycle SHALL present x=x_origin+cnt[2:0], y=y_origin+cnt[5:3], colour=colour register, plot=1 (one-cycle latency).
REQ-027 With writeEnable=0, plot SHALL be 0 next cycle, and x, y and colour SHALL hold.
REQ-028 draw_done SHALL pulse 1 in the cycle after writeEnable=1 and counterEnable=1 with cnt=63, aligned with plot of pixel (7,7).
REQ-029 Arithmetic SHALL be unsigned; x_origin+7 and y_origin+7 SHALL not exceed 159 and 119 (no wrap needed).
REQ-030 The delay FSM SHALL have states IDLE, COUNT and DONE, with a down-counter of ceil(log2(DELAY_CYCLES)) bits.
REQ-031 In any state, ld_delay SHALL load the counter with DELAY_CYCLES-1, clear delay_done and go to COUNT; ld_delay SHALL override delayEN.
REQ-032 In COUNT with delayEN=1 and counter>0, the counter SHALL decrement; with delayEN=0 it SHALL hold (pause, no loss).
REQ-033 In COUNT with delayEN=1 and counter=0, the FSM SHALL go to DONE and delay_done SHALL be 1 next cycle; total latency SHALL be DELAY_CYCLES enabled cycles after arming.
REQ-034 DONE SHALL hold delay_done=1 regardless of delayEN until ld_delay or reset.
REQ-035 In IDLE, delayEN SHALL be ignored and delay_done SHALL be 0.

Reset
REQ-036 While resetn=0 at posedge: x=0, y=0, colour=0, plot=0, draw_done=0, delay_done=0, tile_reg=0, origins=tile0, counter=0, delay FSM=IDLE.
REQ-037 Reset SHALL override all load/enable inputs, and reset mid-draw or mid-delay SHALL abandon the operation with no further plot pulses.

Verification
REQ-038 ld_tile with tile_num=2, then 64 cycles of writeEnable=counterEnable=1 -> 64 plot pulses, first (64,68), last (71,75), colour 3'b001, draw_done on the 64th.
REQ-039 ld_tile with tile_num=1, ld_flash, then draw 64 -> colour 3'b111; then ld_previous and draw 64 -> colour 3'b010, origin (88,44), counter restarted at 0.
REQ-040 DELAY_CYCLES=4: ld_delay, then delayEN=1 continuously -> delay_done rises exactly 4 cycles after delayEN starts; pausing delayEN for 3 cycles mid-count delays the rise by 3.
REQ-041 ld_delay and delayEN asserted together while in DONE -> delay_done=0 next cycle and the counter reloaded to 3.
REQ-042 ld_tile and ld_flash in the same cycle with tile_num=3 -> tile_reg=3, origin (88,68), colour 3'b111.
REQ-043 resetn=0 during pixel 30 of a draw and during COUNT -> next cycle plot=0, delay_done=0, counter=0; no plot pulses until writeEnable is reasserted after reset.
